// File: rtl/controller_multi_pkg.sv
// Shared encodings for the multicycle MIPS controller: FSM states, opcodes,
// R-type funct fields, ALU operation classes and 4-bit ALU-control codes.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_BNEEX   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

endpackage

// File: rtl/controller_multi_aludec.sv
// ALU-control decoder: maps the FSM's aluop class plus the R-type funct field
// to an ALU operation code, zero-extended (or trimmed, all codes fit 3 bits)
// to ALUCTRL_W.
module mc_aludec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           aluop,
    input  logic [5:0]           funct,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    logic [3:0] code;

    // Select the 4-bit operation code from aluop, falling back to funct decode.
    always_comb begin
        code = ALU_AND;
        case (aluop)
            ALUOP_ADD: code = ALU_ADD;
            ALUOP_SUB: code = ALU_SUB;
            default: begin
                case (funct)
                    FN_ADD:  code = ALU_ADD;
                    FN_SUB:  code = ALU_SUB;
                    FN_AND:  code = ALU_AND;
                    FN_OR:   code = ALU_OR;
                    FN_SLT:  code = ALU_SLT;
                    default: code = ALU_AND;
                endcase
            end
        endcase
    end

    assign alucontrol = (ALUCTRL_W)'(code);

endmodule

// File: rtl/controller_multi.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute
// and writeback over a shared memory and ALU, with an optional memory
// wait-state handshake (MEM_HANDSHAKE).
// Build option: CTRL_MC_BNE_EN adds a BNE execute state (12); without it
// opcode 000101 decodes as an unknown op and returns straight to FETCH.
//
// state      | meaning
// FETCH   0  | read instruction at PC, PC <= PC+4 when memory ready
// DECODE  1  | read registers, compute branch target
// MEMADR  2  | compute load/store address
// MEMRD   3  | memory read, wait for mem_ready
// MEMWB   4  | write loaded data to rt
// MEMWR   5  | memory write, strobe held until mem_ready
// RTYPEEX 6  | R-type ALU operation
// RTYPEWB 7  | write ALU result to rd
// BEQEX   8  | compare, branch if zero
// ADDIEX  9  | add immediate
// ADDIWB 10  | write ALU result to rt
// JEX    11  | load jump target into PC
// BNEEX  12  | compare, branch if not zero (optional)
module controller_multi
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W     = 4,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [5:0]           op,
    input  logic [5:0]           funct,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 iord,
    output logic                 memwrite,
    output logic                 irwrite,
    output logic                 regdst,
    output logic                 memtoreg,
    output logic                 regwrite,
    output logic                 alusrca,
    output logic [1:0]           alusrcb,
    output logic [1:0]           pcsrc,
    output logic                 pcen,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic [3:0]           state_o
);

    state_t     state, state_nxt;
    logic       ready;
    logic [1:0] aluop;
    logic       pcwrite, branch, bne;
    logic       irwrite_s, memwrite_s, regwrite_s;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // State register; reset aborts any instruction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_nxt;
    end

    // Next-state selection and per-state control outputs.
    always_comb begin
        state_nxt  = state;
        iord       = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        regwrite_s = 1'b0;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        aluop      = ALUOP_ADD;
        pcwrite    = 1'b0;
        branch     = 1'b0;
        bne        = 1'b0;
        case (state)
            S_FETCH: begin
                alusrcb   = 2'b01;
                irwrite_s = ready;
                pcwrite   = ready;
                if (ready) state_nxt = S_DECODE;
            end
            S_DECODE: begin
                alusrcb = 2'b11;
                case (op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_RTYPEEX;
                    OP_BEQ:       state_nxt = S_BEQEX;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JEX;
`ifdef CTRL_MC_BNE_EN
                    OP_BNE:       state_nxt = S_BNEEX;
`endif
                    default:      state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                state_nxt = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord = 1'b1;
                if (ready) state_nxt = S_MEMWB;
            end
            S_MEMWB: begin
                memtoreg   = 1'b1;
                regwrite_s = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWR: begin
                iord       = 1'b1;
                memwrite_s = 1'b1;
                if (ready) state_nxt = S_FETCH;
            end
            S_RTYPEEX: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_FUNCT;
                state_nxt = S_RTYPEWB;
            end
            S_RTYPEWB: begin
                regdst     = 1'b1;
                regwrite_s = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BEQEX: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc     = 2'b01;
                branch    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca   = 1'b1;
                alusrcb   = 2'b10;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JEX: begin
                pcsrc     = 2'b10;
                pcwrite   = 1'b1;
                state_nxt = S_FETCH;
            end
`ifdef CTRL_MC_BNE_EN
            S_BNEEX: begin
                alusrca   = 1'b1;
                aluop     = ALUOP_SUB;
                pcsrc     = 2'b01;
                bne       = 1'b1;
                state_nxt = S_FETCH;
            end
`endif
            default: state_nxt = S_FETCH;
        endcase
    end

    // Write enables are held off for as long as reset is asserted.
    assign irwrite  = irwrite_s  & ~reset;
    assign memwrite = memwrite_s & ~reset;
    assign regwrite = regwrite_s & ~reset;
    assign pcen     = (pcwrite | (branch & zero) | (bne & ~zero)) & ~reset;
    assign state_o  = state;

    mc_aludec #(
        .ALUCTRL_W(ALUCTRL_W)
    ) u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule
